// File: rtl/renode_axi_pkg.sv
// Shared AXI types for the Renode AXI subordinate memory.
// Burst/response encodings and the burst support check.
package renode_axi_pkg;
  typedef enum logic [1:0] {
    Fixed = 2'd0,
    Incr  = 2'd1,
    Wrap  = 2'd2
  } burst_type_e;

  typedef enum logic [1:0] {
    Okay          = 2'd0,
    ExclusiveOkay = 2'd1,
    SlaveError    = 2'd2,
    DecodeError   = 2'd3
  } response_e;

  typedef logic [2:0] burst_size_t;

  function automatic logic is_burst_supported(
    input logic [1:0] burst
  );
    return (burst == 2'(Fixed)) ||
           (burst == 2'(Incr));
  endfunction
endpackage

// File: rtl/renode_axi_burst_address.sv
// Next beat address and last-beat compare for one AXI burst.
// WRAP and reserved bursts hold the address; they are flagged elsewhere.
module renode_axi_burst_address
  import renode_axi_pkg::*;
#(
  parameter int AddressWidth = 20
) (
  input  logic [AddressWidth-1:0] i_addr,
  input  burst_size_t             i_size,
  input  logic [1:0]              i_burst,
  input  logic [7:0]              i_count,
  input  logic [7:0]              i_len,
  output logic [AddressWidth-1:0] o_next_addr,
  output logic                    o_last
);
  always_comb begin
    o_next_addr = i_addr;
    if (i_burst == 2'(Incr))
      o_next_addr = i_addr +
        (AddressWidth'(1) << i_size);
  end

  assign o_last = (i_count == i_len);
endmodule

// File: rtl/renode_axi_subordinate_mem.sv
// AXI4 subordinate backed by a word-addressed memory.
// Independent read and write FSMs, one transaction each.
module renode_axi_subordinate_mem
  import renode_axi_pkg::*;
#(
  parameter  int AddressWidth       = 20,
  parameter  int DataWidth          = 32,
  parameter  int TransactionIdWidth = 8,
  parameter  int MemoryDepth        = 1024,
  localparam int StrobeWidth        = DataWidth / 8
) (
  input  logic                          aclk,
  input  logic                          areset_n,
  input  logic [TransactionIdWidth-1:0] awid,
  input  logic [AddressWidth-1:0]       awaddr,
  input  logic [7:0]                    awlen,
  input  logic [2:0]                    awsize,
  input  logic [1:0]                    awburst,
  input  logic                          awlock,
  input  logic [2:0]                    awprot,
  input  logic                          awvalid,
  output logic                          awready,
  input  logic [DataWidth-1:0]          wdata,
  input  logic [StrobeWidth-1:0]        wstrb,
  input  logic                          wlast,
  input  logic                          wvalid,
  output logic                          wready,
  output logic [TransactionIdWidth-1:0] bid,
  output logic [1:0]                    bresp,
  output logic                          bvalid,
  input  logic                          bready,
  input  logic [TransactionIdWidth-1:0] arid,
  input  logic [AddressWidth-1:0]       araddr,
  input  logic [7:0]                    arlen,
  input  logic [2:0]                    arsize,
  input  logic [1:0]                    arburst,
  input  logic                          arlock,
  input  logic [2:0]                    arprot,
  input  logic                          arvalid,
  output logic                          arready,
  output logic [TransactionIdWidth-1:0] rid,
  output logic [DataWidth-1:0]          rdata,
  output logic [1:0]                    rresp,
  output logic                          rlast,
  output logic                          rvalid,
  input  logic                          rready
);
  localparam int AddrLsb    = $clog2(StrobeWidth);
  localparam int IndexWidth = $clog2(MemoryDepth);

  typedef enum logic [1:0] {
    W_IDLE, W_DATA, W_RESP
  } wstate_e;
  typedef enum logic {
    R_IDLE, R_DATA
  } rstate_e;

  function automatic logic in_range(
    input logic [AddressWidth-1:0] a
  );
    return (a >> AddrLsb) <
           AddressWidth'(MemoryDepth);
  endfunction

  function automatic logic [IndexWidth-1:0]
    word_index(input logic [AddressWidth-1:0] a);
    return IndexWidth'(a >> AddrLsb);
  endfunction

  function automatic logic txn_ok(
    input logic [1:0] burst,
    input burst_size_t size
  );
    return is_burst_supported(burst) &&
           (size <= 3'(AddrLsb));
  endfunction

  logic [DataWidth-1:0] r_mem [MemoryDepth];

  wstate_e                   r_wstate;
  logic                      r_awready;
  logic                      r_wready;
  logic                      r_bvalid;
  logic [TransactionIdWidth-1:0] r_bid;
  response_e                 r_bresp;
  logic [TransactionIdWidth-1:0] r_awid;
  logic [AddressWidth-1:0]   r_waddr;
  logic [7:0]                r_awlen;
  burst_size_t               r_awsize;
  logic [1:0]                r_awburst;
  logic [7:0]                r_wcnt;
  logic                      r_werr;

  rstate_e                   r_rstate;
  logic                      r_arready;
  logic                      r_rvalid;
  logic [TransactionIdWidth-1:0] r_rid;
  logic [DataWidth-1:0]      r_rdata;
  response_e                 r_rresp;
  logic                      r_rlast;
  logic [AddressWidth-1:0]   r_raddr;
  logic [7:0]                r_arlen;
  burst_size_t               r_arsize;
  logic [1:0]                r_arburst;
  logic [7:0]                r_rcnt;

  logic [AddressWidth-1:0] w_wnext;
  logic                    w_wlast_exp;
  logic                    w_wfire;
  logic                    w_wbeat_ok;
  logic                    w_wbeat_err;
  logic                    w_mem_we;
  logic [IndexWidth-1:0]   w_widx;

  logic [AddressWidth-1:0] w_rnext;
  logic                    w_rnext_last;
  logic [7:0]              w_rcnt_next;
  logic                    w_rfire;
  logic [AddressWidth-1:0] w_rsrc_addr;
  logic                    w_rsrc_ok;
  logic                    w_rbeat_ok;
  logic [DataWidth-1:0]    w_rword;
  logic                    w_unused;

  assign w_unused =
    ^{awlock, awprot, arlock, arprot};

  renode_axi_burst_address #(
    .AddressWidth(AddressWidth)
  ) u_waddr (
    .i_addr     (r_waddr),
    .i_size     (r_awsize),
    .i_burst    (r_awburst),
    .i_count    (r_wcnt),
    .i_len      (r_awlen),
    .o_next_addr(w_wnext),
    .o_last     (w_wlast_exp)
  );

  // Read side looks one beat ahead to prefetch.
  assign w_rcnt_next = r_rcnt + 8'd1;

  renode_axi_burst_address #(
    .AddressWidth(AddressWidth)
  ) u_raddr (
    .i_addr     (r_raddr),
    .i_size     (r_arsize),
    .i_burst    (r_arburst),
    .i_count    (w_rcnt_next),
    .i_len      (r_arlen),
    .o_next_addr(w_rnext),
    .o_last     (w_rnext_last)
  );

  assign w_wfire     = r_wready & wvalid;
  assign w_wbeat_ok  = txn_ok(r_awburst, r_awsize) &&
                       in_range(r_waddr);
  assign w_wbeat_err = !w_wbeat_ok ||
                       (wlast != w_wlast_exp);
  assign w_mem_we    = w_wfire && w_wbeat_ok;
  assign w_widx      = word_index(r_waddr);

  always_ff @(posedge aclk) begin
    if (w_mem_we)
      for (int b = 0; b < StrobeWidth; b++)
        if (wstrb[b])
          r_mem[w_widx][b*8 +: 8] <= wdata[b*8 +: 8];
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bid     <= '0;
      r_bresp   <= Okay;
      r_awid    <= '0;
      r_waddr   <= '0;
      r_awlen   <= '0;
      r_awsize  <= '0;
      r_awburst <= '0;
      r_wcnt    <= '0;
      r_werr    <= 1'b0;
    end else begin
      unique case (r_wstate)
        W_IDLE: begin
          r_awready <= 1'b1;
          if (r_awready && awvalid) begin
            r_awid    <= awid;
            r_waddr   <= awaddr;
            r_awlen   <= awlen;
            r_awsize  <= awsize;
            r_awburst <= awburst;
            r_wcnt    <= '0;
            r_werr    <= 1'b0;
            r_awready <= 1'b0;
            r_wready  <= 1'b1;
            r_wstate  <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_wfire) begin
            r_waddr <= w_wnext;
            r_wcnt  <= r_wcnt + 8'd1;
            r_werr  <= r_werr | w_wbeat_err;
            if (w_wlast_exp) begin
              r_wready <= 1'b0;
              r_bvalid <= 1'b1;
              r_bid    <= r_awid;
              r_bresp  <= (r_werr | w_wbeat_err) ?
                          SlaveError : Okay;
              r_wstate <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            r_bvalid  <= 1'b0;
            r_bresp   <= Okay;
            r_awready <= 1'b1;
            r_wstate  <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  assign w_rfire     = r_rvalid & rready;
  assign w_rsrc_addr = (r_rstate == R_IDLE) ?
                       araddr : w_rnext;
  assign w_rsrc_ok   = (r_rstate == R_IDLE) ?
                       txn_ok(arburst, arsize) :
                       txn_ok(r_arburst, r_arsize);
  assign w_rbeat_ok  = w_rsrc_ok && in_range(w_rsrc_addr);
  assign w_rword     = r_mem[word_index(w_rsrc_addr)];

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rid     <= '0;
      r_rdata   <= '0;
      r_rresp   <= Okay;
      r_rlast   <= 1'b0;
      r_raddr   <= '0;
      r_arlen   <= '0;
      r_arsize  <= '0;
      r_arburst <= '0;
      r_rcnt    <= '0;
    end else begin
      unique case (r_rstate)
        R_IDLE: begin
          r_arready <= 1'b1;
          if (r_arready && arvalid) begin
            r_rid     <= arid;
            r_raddr   <= araddr;
            r_arlen   <= arlen;
            r_arsize  <= arsize;
            r_arburst <= arburst;
            r_rcnt    <= '0;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b1;
            r_rlast   <= (arlen == 8'd0);
            r_rdata   <= w_rbeat_ok ? w_rword : '0;
            r_rresp   <= w_rbeat_ok ? Okay : SlaveError;
            r_rstate  <= R_DATA;
          end
        end
        R_DATA: begin
          if (w_rfire) begin
            if (r_rlast) begin
              r_rvalid  <= 1'b0;
              r_rlast   <= 1'b0;
              r_rdata   <= '0;
              r_rresp   <= Okay;
              r_arready <= 1'b1;
              r_rstate  <= R_IDLE;
            end else begin
              r_raddr <= w_rnext;
              r_rcnt  <= w_rcnt_next;
              r_rlast <= w_rnext_last;
              r_rdata <= w_rbeat_ok ? w_rword : '0;
              r_rresp <= w_rbeat_ok ? Okay : SlaveError;
            end
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  assign awready = r_awready;
  assign wready  = r_wready;
  assign bvalid  = r_bvalid;
  assign bid     = r_bid;
  assign bresp   = r_bresp;
  assign arready = r_arready;
  assign rvalid  = r_rvalid;
  assign rid     = r_rid;
  assign rdata   = r_rdata;
  assign rresp   = r_rresp;
  assign rlast   = r_rlast;
endmodule

// File: tb/tb_renode_axi_subordinate_mem.sv
// Directed bench for renode_axi_subordinate_mem.
// Vector table for single beats, sequences for bursts and reset.
module tb_renode_axi_subordinate_mem;
  logic        aclk = 1'b0;
  logic        areset_n = 1'b0;
  logic [7:0]  awid, arid, bid, rid;
  logic [19:0] awaddr, araddr;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize, awprot, arprot;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awlock, arlock;
  logic        awvalid, awready, wvalid, wready;
  logic        bvalid, bready, arvalid, arready;
  logic        rvalid, rready, rlast, wlast;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;

  always #5 aclk = ~aclk;

  renode_axi_subordinate_mem dut (
    .aclk(aclk), .areset_n(areset_n),
    .awid(awid), .awaddr(awaddr), .awlen(awlen),
    .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awprot(awprot),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp),
    .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arprot(arprot),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp),
    .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  int checks = 0;
  int failures = 0;

  logic [31:0] wbuf [8];
  logic [31:0] rd_data [8];
  logic [1:0]  rd_resp [8];
  logic        rd_last [8];
  logic [7:0]  rd_id0;
  int          rd_n;
  int          stab_err;
  logic [1:0]  b_resp;
  logic [7:0]  b_id;

  typedef struct {
    logic [19:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  size;
    logic [1:0]  bresp;
    logic [19:0] raddr;
    logic [31:0] rdata;
  } vec_t;
  vec_t vec [10];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, exp);
    end
  endtask

  task automatic tmo(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=handshake",
             name);
  endtask

  task automatic do_write(input logic [7:0] id,
                          input logic [19:0] addr,
                          input logic [7:0] len,
                          input logic [2:0] size,
                          input logic [1:0] burst,
                          input logic [3:0] strb,
                          input int last_beat);
    int t;
    awid = id; awaddr = addr; awlen = len;
    awsize = size; awburst = burst; awvalid = 1'b1;
    t = 0;
    while (!awready && t < 100) begin
      @(posedge aclk); #1; t++;
    end
    if (t >= 100) tmo("aw_wait");
    @(posedge aclk); #1;
    awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wdata = wbuf[i]; wstrb = strb;
      wlast = (i == last_beat); wvalid = 1'b1;
      t = 0;
      while (!wready && t < 100) begin
        @(posedge aclk); #1; t++;
      end
      if (t >= 100) tmo("w_wait");
      @(posedge aclk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
    t = 0;
    while (!bvalid && t < 100) begin
      @(posedge aclk); #1; t++;
    end
    if (t >= 100) tmo("b_wait");
    b_resp = bresp; b_id = bid;
    @(posedge aclk); #1;
    bready = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] id,
                         input logic [19:0] addr,
                         input logic [7:0] len,
                         input logic [2:0] size,
                         input logic [1:0] burst,
                         input logic stall,
                         input int stop_after);
    int t, cyc;
    logic prev_stall, s_last;
    logic [31:0] s_data;
    logic [1:0] s_resp;
    arid = id; araddr = addr; arlen = len;
    arsize = size; arburst = burst; arvalid = 1'b1;
    t = 0;
    while (!arready && t < 100) begin
      @(posedge aclk); #1; t++;
    end
    if (t >= 100) tmo("ar_wait");
    @(posedge aclk); #1;
    arvalid = 1'b0;
    rd_n = 0; stab_err = 0; cyc = 0;
    prev_stall = 1'b0;
    s_data = '0; s_resp = '0; s_last = 1'b0;
    while (rd_n < stop_after && rd_n < 8 && cyc < 200) begin
      rready = stall ? (cyc % 2 == 1) : 1'b1;
      if (prev_stall && (!rvalid || rdata !== s_data ||
          rresp !== s_resp || rlast !== s_last))
        stab_err++;
      prev_stall = rvalid && !rready;
      s_data = rdata; s_resp = rresp; s_last = rlast;
      if (rvalid && rready) begin
        if (rd_n == 0) rd_id0 = rid;
        rd_data[rd_n] = rdata;
        rd_resp[rd_n] = rresp;
        rd_last[rd_n] = rlast;
        rd_n++;
      end
      @(posedge aclk); #1;
      cyc++;
      if (rd_n > 0 && rd_last[rd_n-1]) break;
    end
    rready = 1'b0;
    if (cyc >= 200) tmo("r_wait");
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vec[0] = '{20'h010, 32'hDEADBEEF, 4'hF, 3'd2, 2'd0, 20'h010, 32'hDEADBEEF};
    vec[1] = '{20'h020, 32'h11223344, 4'hF, 3'd2, 2'd0, 20'h020, 32'h11223344};
    vec[2] = '{20'h022, 32'h00AB0000, 4'h4, 3'd0, 2'd0, 20'h020, 32'h11AB3344};
    vec[3] = '{20'h030, 32'h01020304, 4'hF, 3'd2, 2'd0, 20'h030, 32'h01020304};
    vec[4] = '{20'h032, 32'hAABBCCDD, 4'hC, 3'd1, 2'd0, 20'h030, 32'hAABB0304};
    vec[5] = '{20'hFFC, 32'h5A5A5A5A, 4'hF, 3'd2, 2'd0, 20'hFFC, 32'h5A5A5A5A};
    vec[6] = '{20'h000, 32'h0BADF00D, 4'hF, 3'd2, 2'd0, 20'h000, 32'h0BADF00D};
    vec[7] = '{20'h1000, 32'hCAFEF00D, 4'hF, 3'd2, 2'd2, 20'h000, 32'h0BADF00D};
    vec[8] = '{20'h040, 32'h12345678, 4'hF, 3'd2, 2'd0, 20'h040, 32'h12345678};
    vec[9] = '{20'h040, 32'hFFFFFFFF, 4'hF, 3'd3, 2'd2, 20'h040, 32'h12345678};

    awid = '0; awaddr = '0; awlen = '0; awsize = '0;
    awburst = '0; awlock = 1'b0; awprot = '0;
    awvalid = 1'b0; wdata = '0; wstrb = '0;
    wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0;
    arburst = '0; arlock = 1'b0; arprot = '0;
    arvalid = 1'b0; rready = 1'b0;
    for (int i = 0; i < 8; i++) wbuf[i] = '0;

    repeat (3) @(posedge aclk);
    #1;
    chk("rst_awready", 32'(awready), 0);
    chk("rst_wready", 32'(wready), 0);
    chk("rst_bvalid", 32'(bvalid), 0);
    chk("rst_arready", 32'(arready), 0);
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_rdata", rdata, 0);
    @(negedge aclk);
    areset_n = 1'b1;
    #1;
    chk("rel_awready_pre", 32'(awready), 0);
    @(posedge aclk); #1;
    chk("rel_awready", 32'(awready), 1);
    chk("rel_arready", 32'(arready), 1);

    for (int i = 0; i < 10; i++) begin
      wbuf[0] = vec[i].wdata;
      do_write(8'(i + 1), vec[i].addr, 8'd0, vec[i].size,
               2'd1, vec[i].strb, 0);
      chk($sformatf("v%0d_bresp", i), 32'(b_resp),
          32'(vec[i].bresp));
      chk($sformatf("v%0d_bid", i), 32'(b_id), i + 1);
      do_read(8'(i + 1), vec[i].raddr, 8'd0, 3'd2,
              2'd1, 1'b0, 99);
      chk($sformatf("v%0d_rn", i), rd_n, 1);
      chk($sformatf("v%0d_rdata", i), rd_data[0],
          vec[i].rdata);
      chk($sformatf("v%0d_rresp", i), 32'(rd_resp[0]), 0);
      chk($sformatf("v%0d_rlast", i), 32'(rd_last[0]), 1);
      chk($sformatf("v%0d_rid", i), 32'(rd_id0), i + 1);
    end

    for (int k = 0; k < 4; k++) wbuf[k] = 32'(k + 1);
    do_write(8'hA5, 20'h100, 8'd3, 3'd2, 2'd1, 4'hF, 3);
    chk("incr_bresp", 32'(b_resp), 0);
    chk("incr_bid", 32'(b_id), 32'hA5);
    do_read(8'h5A, 20'h100, 8'd3, 3'd2, 2'd1, 1'b1, 99);
    chk("incr_rn", rd_n, 4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("incr_d%0d", k), rd_data[k], 32'(k + 1));
      chk($sformatf("incr_r%0d", k), 32'(rd_resp[k]), 0);
      chk($sformatf("incr_l%0d", k), 32'(rd_last[k]),
          32'(k == 3));
    end
    chk("incr_rid", 32'(rd_id0), 32'h5A);
    chk("incr_stable", stab_err, 0);

    wbuf[0] = 32'h7; wbuf[1] = 32'h8;
    do_write(8'h01, 20'h050, 8'd1, 3'd2, 2'd0, 4'hF, 1);
    chk("fixed_bresp", 32'(b_resp), 0);
    do_read(8'h02, 20'h050, 8'd0, 3'd2, 2'd1, 1'b0, 99);
    chk("fixed_wdata", rd_data[0], 32'h8);
    do_read(8'h03, 20'h100, 8'd1, 3'd2, 2'd0, 1'b0, 99);
    chk("fixed_rn", rd_n, 2);
    chk("fixed_r0", rd_data[0], 32'h1);
    chk("fixed_r1", rd_data[1], 32'h1);

    do_read(8'h04, 20'h010, 8'd1, 3'd2, 2'd2, 1'b0, 99);
    chk("wrap_rn", rd_n, 2);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("wrap_d%0d", k), rd_data[k], 0);
      chk($sformatf("wrap_r%0d", k), 32'(rd_resp[k]), 2);
    end
    chk("wrap_l1", 32'(rd_last[1]), 1);
    do_read(8'h05, 20'h1000, 8'd0, 3'd2, 2'd1, 1'b0, 99);
    chk("oor_rdata", rd_data[0], 0);
    chk("oor_rresp", 32'(rd_resp[0]), 2);
    do_read(8'h06, 20'hFFC, 8'd1, 3'd2, 2'd1, 1'b0, 99);
    chk("edge_d0", rd_data[0], 32'h5A5A5A5A);
    chk("edge_r0", 32'(rd_resp[0]), 0);
    chk("edge_d1", rd_data[1], 0);
    chk("edge_r1", 32'(rd_resp[1]), 2);

    wbuf[0] = 32'h9; wbuf[1] = 32'hA;
    do_write(8'h06, 20'h060, 8'd1, 3'd2, 2'd1, 4'hF, 0);
    chk("wlast_bresp", 32'(b_resp), 2);

    do_read(8'h07, 20'h100, 8'd3, 3'd2, 2'd1, 1'b0, 2);
    chk("mid_rn", rd_n, 2);
    chk("mid_d1", rd_data[1], 32'h2);
    chk("mid_rvalid_pre", 32'(rvalid), 1);
    areset_n = 1'b0;
    #1;
    chk("mid_rvalid_rst", 32'(rvalid), 0);
    chk("mid_arready_rst", 32'(arready), 0);
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    areset_n = 1'b1;
    #1;
    chk("mid_arready_pre", 32'(arready), 0);
    @(posedge aclk); #1;
    chk("mid_arready_rel", 32'(arready), 1);
    chk("mid_rvalid_rel", 32'(rvalid), 0);
    do_read(8'h08, 20'h010, 8'd0, 3'd2, 2'd1, 1'b0, 99);
    chk("post_rdata", rd_data[0], 32'hDEADBEEF);
    chk("post_rresp", 32'(rd_resp[0]), 0);
    chk("post_rid", 32'(rd_id0), 32'h08);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule

// File: doc/renode_axi_subordinate_mem.md
Name: renode_axi_subordinate_mem

Overview:
- Synthesizable AXI4 subordinate (responder) backed by an internal word-addressed memory array.
- Pairs with the Renode AXI manager in co-simulation: it is the loopback target for manager regression, and the reference subordinate model for HDL peripherals.
- Independent read and write FSMs, one outstanding transaction per direction.
- Supports FIXED/INCR bursts, narrow transfers and byte strobes.

Parameters:
- AddressWidth, 20, byte-address width of awaddr/araddr.
- DataWidth, 32, data bus width (32 or 64); StrobeWidth = DataWidth/8 is a localparam.
- TransactionIdWidth, 8, width of the id signals.
- MemoryDepth, 1024, number of DataWidth-wide words.

Ports:
- aclk  in  1  clock
- areset_n  in  1  asynchronous active-low reset
- awid/awaddr/awlen/awsize/awburst  in  TransactionIdWidth/AddressWidth/8/3/2  write address payload
- awvalid in 1, awready out 1  AW handshake
- wdata/wstrb/wlast  in  DataWidth/StrobeWidth/1  write data payload
- wvalid in 1, wready out 1  W handshake
- bid/bresp  out  TransactionIdWidth/2  write response
- bvalid out 1, bready in 1  B handshake
- arid/araddr/arlen/arsize/arburst  in  TransactionIdWidth/AddressWidth/8/3/2  read address payload
- arvalid in 1, arready out 1  AR handshake
- rid/rdata/rresp/rlast  out  TransactionIdWidth/DataWidth/2/1  read data payload
- rvalid out 1, rready in 1  R handshake
- awlock/awprot/arlock/arprot are accepted and ignored.

Behaviour:
- Reset (async assert, sync release):
  - All outputs are 0, both FSMs go to IDLE, error flags clear.
  - awready/arready first rise on the first aclk edge after areset_n is released.
  - Memory contents are not reset.
  - Reset mid-transaction aborts it; no B or R beat is issued for the aborted transaction.
- Word index = addr >> log2(StrobeWidth). Out of range when index >= MemoryDepth.
- Next beat address:
  - FIXED: unchanged.
  - INCR: addr + (1<<size), computed at AddressWidth bits; wraps modulo 2^AddressWidth, and 4KB crossing is not checked.
  - WRAP or reserved burst type: unsupported.
- Unsupported burst, or size > log2(StrobeWidth), sets a transaction-wide SLVERR.
- Write FSM (W_IDLE -> W_DATA -> W_RESP):
  - W_IDLE: awready=1. On AW handshake, latch id/addr/len/size/burst, clear beat counter and error flag, go to W_DATA.
  - W_DATA: wready=1. On each W handshake:
    - If the transaction is valid and the address is in range, write the wstrb-enabled bytes into the memory word.
    - Otherwise discard the beat and set the sticky error.
    - Advance address and counter.
    - wlast must equal (counter==awlen); any mismatch sets the sticky error.
    - The beat with counter==awlen moves to W_RESP.
  - W_RESP: bvalid=1, bid=latched id, bresp=SLVERR(2'b10) if the error flag is set, else OKAY(2'b00). On bready, go to W_IDLE.
  - awready=0 outside W_IDLE. W beats presented in W_IDLE are not accepted (wready=0).
- Read FSM (R_IDLE -> R_DATA):
  - R_IDLE: arready=1. On AR handshake, latch the request and register beat 0 from memory; rvalid rises the next cycle (1-cycle latency).
  - R_DATA: rvalid=1, rid=latched id, rlast=(counter==arlen).
    - rresp=SLVERR with rdata=0 for an out-of-range beat or an unsupported transaction; otherwise OKAY with the full word (no lane masking).
    - On R handshake with rlast=0: register the next beat, keeping rvalid continuous (no bubble).
    - On R handshake with rlast=1: go to R_IDLE.
  - rvalid held with payload stable while rready=0.
- Read and write are fully concurrent. A read capturing the same word in the cycle it is written returns the old value (read-before-write).
- An ID is never reordered (single outstanding transaction per direction).

Decomposition:
- renode_axi_pkg gains:
  - burst_type_e (Fixed=0, Incr=1, Wrap=2)
  - constant Okay/SlaveError usage of the existing response_e
  - function is_burst_supported
- burst_size_t is reused from the package.
- One sub-module, renode_axi_burst_address: combinational next-address plus beat-count compare. It is instantiated once per FSM.

Test Plan:
- Single-beat write addr 0x10, data 0xDEADBEEF, wstrb 4'hF, then read 0x10 -> bresp=OKAY; rdata=0xDEADBEEF, rresp=OKAY, rlast=1, rid=awid.
- Write 0x11223344 to 0x20, then byte write at 0x22 with wdata 0x00AB0000, awsize=0, wstrb 4'b0100; read 0x20 -> 0x11AB3344.
- INCR burst awlen=3 at 0x100 with data 1,2,3,4; INCR read arlen=3 with rready toggling every cycle -> 1,2,3,4 in order, rlast only on beat 4, payload stable while stalled.
- Write to index MemoryDepth (addr 0x1000 at defaults), and read with arburst=Wrap -> bresp=SLVERR with memory unchanged; every R beat SLVERR with rdata=0.
- Burst awlen=1 with wlast asserted on beat 0 -> bresp=SLVERR. Then areset_n pulse mid read burst (after beat 1 of 4) -> rvalid=0 immediately, arready=1 on the first edge after release, next read works.
